ysyx_24090003_csr_unit: RTL

- Machine-mode CSR register file and trap-state holder for the single-cycle RV32 core.
- Supplies the CSR read data, mtvec and mepc values that the execute stage consumes.
- Takes the execute stage's CSR write data, ecall/mret strobes and the current PC, and commits CSR state on the clock edge when the instruction retires.
- Owns mstatus/mtvec/mepc/mcause, the read-only ID CSRs and an optional 64-bit cycle counter.

---
 rtl/ysyx_24090003_csr_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ysyx_24090003_csr_unit.sv
// rtl/ysyx_24090003_csr_unit.sv - machine-mode CSR file and trap state for the single-cycle RV32 core
// Optional mcycle/mcycleh counter is built when YSYX_24090003_MCYCLE_EN is defined.
module ysyx_24090003_csr_unit #(
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] MVENDORID   = 32'h7973_7978,
  parameter logic [31:0] MARCHID     = 32'h016F_9593
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_commit,
  input  logic        i_csr_en,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_csr_addr,
  input  logic [4:0]  i_rs1_idx,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic [31:0] i_pc,
  output logic [31:0] o_csr_rdata,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc,
  output logic        o_csr_illegal
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
`ifdef YSYX_24090003_MCYCLE_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
`endif

  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
`ifdef YSYX_24090003_MCYCLE_EN
  logic [63:0] mcycle;
`endif

  logic        impl;
  logic        ro;
  logic [31:0] old_val;
  logic [31:0] src;
  logic [31:0] new_val;
  logic        wr_attempt;
  logic        csr_we;

  always_comb begin
    impl    = 1'b1;
    ro      = 1'b0;
    old_val = 32'd0;
    case (i_csr_addr)
      A_MSTATUS:   old_val = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
      A_MTVEC:     old_val = mtvec;
      A_MEPC:      old_val = mepc;
      A_MCAUSE:    old_val = mcause;
      A_MVENDORID: begin old_val = MVENDORID; ro = 1'b1; end
      A_MARCHID:   begin old_val = MARCHID;   ro = 1'b1; end
`ifdef YSYX_24090003_MCYCLE_EN
      A_MCYCLE:    old_val = mcycle[31:0];
      A_MCYCLEH:   old_val = mcycle[63:32];
`endif
      default:     impl = 1'b0;
    endcase
  end

  always_comb begin
    src = i_funct3[2] ? {27'd0, i_rs1_idx} : i_csr_wdata;
    case (i_funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with rs1=0 is a pure read, so it never counts as a write attempt.
  assign wr_attempt    = (i_funct3[1:0] == 2'b01) | (i_funct3[1] & (|i_rs1_idx));
  assign csr_we        = i_commit & i_csr_en & impl & ~ro & wr_attempt & ~i_ecall & ~i_mret;
  assign o_csr_illegal = i_csr_en & (~impl | (ro & wr_attempt));
  assign o_csr_rdata   = i_csr_en ? old_val : 32'd0;
  assign o_mtvec       = mtvec;
  assign o_mepc        = mepc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mie    <= MSTATUS_RST[3];
      mpie   <= MSTATUS_RST[7];
      mtvec  <= 32'd0;
      mepc   <= 32'd0;
      mcause <= 32'd0;
    end else if (i_commit & i_ecall) begin
      mepc   <= {i_pc[31:2], 2'b00};
      mcause <= 32'd11;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (i_commit & i_mret) begin
      mie    <= mpie;
      mpie   <= 1'b1;
    end else if (csr_we) begin
      case (i_csr_addr)
        A_MSTATUS: begin
          mie  <= new_val[3];
          mpie <= new_val[7];
        end
        A_MTVEC:  mtvec  <= {new_val[31:2], 2'b00};
        A_MEPC:   mepc   <= {new_val[31:2], 2'b00};
        A_MCAUSE: mcause <= new_val;
        default:  ;
      endcase
    end
  end

`ifdef YSYX_24090003_MCYCLE_EN
  // Counter runs regardless of commit; a high-half write blocks the carry that cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcycle <= 64'd0;
    end else if (csr_we && i_csr_addr == A_MCYCLE) begin
      mcycle <= {mcycle[63:32], new_val};
    end else if (csr_we && i_csr_addr == A_MCYCLEH) begin
      mcycle <= {new_val, mcycle[31:0] + 32'd1};
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end
`endif

endmodule
